// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Stall/flush controller for the 5-stage pipeline. It works alongside the
// forwarding unit. It holds the front end when an operand does not exist yet,
// and squashes wrong-path instructions after a taken branch.
//
// It handles three cases:
//   - Load-use dependency: one bubble is inserted into ID/EX.
//   - Multicycle MDU op in EX: a fixed-latency freeze of MDU_LAT-1 cycles,
//     then one release cycle with mdu_done.
//   - Taken branch resolved in EX: IF/ID and ID/EX are flushed.
//
// The outputs are Mealy: they are decoded combinationally from state, cnt and
// the current inputs, so a stall takes effect in the cycle that detects it.
// Only state and cnt are registered.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   When it is defined, three saturating 32-bit event counters are added:
//   load_stall_cnt, mdu_stall_cnt and flush_cnt.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   rs1, rs2       in   ID-stage source registers
//   ID_EX_reg      in   destination register of the instruction in EX
//   ID_EX_memRead  in   instruction in EX is a load
//   mdu_start      in   instruction in EX is an MDU op (held while in EX)
//   branch_taken   in   taken branch/jump resolved in EX this cycle
//   pc_write       out  PC register enable
//   if_id_write    out  IF/ID register enable
//   if_id_flush    out  IF/ID loads NOP
//   id_ex_flush    out  ID/EX loads bubble
//   ex_hold        out  ID/EX holds, EX/MEM loads bubble
//   mdu_busy       out  FSM is in MDU_BUSY
//   mdu_done       out  MDU result valid; release cycle
//   load_stall_cnt, mdu_stall_cnt, flush_cnt (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int WIDTH   = 5,
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [WIDTH-1:0] ID_EX_reg,
    input  logic             ID_EX_memRead,
    input  logic             mdu_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_hold,
    output logic             mdu_busy,
    output logic             mdu_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      load_stall_cnt,
    output logic [31:0]      mdu_stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;

    // x0 is hardwired to zero, so it can never be the source of a hazard.
    assign load_use = ID_EX_memRead && (ID_EX_reg != '0) &&
                      ((rs1 == ID_EX_reg) || (rs2 == ID_EX_reg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_hold     = 1'b0;
        mdu_busy    = 1'b0;
        mdu_done    = 1'b0;

        // While reset is asserted, the outputs stay at their pass-through
        // values regardless of the inputs. A reset mid-MDU therefore releases
        // the pipe at once and never produces a done pulse.
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (branch_taken) begin
                        // A branch in EX together with mdu_start is an illegal
                        // combination; the flush wins and the MDU is not entered.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mdu_start) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_hold     = 1'b1;
                        state_d     = MDU_BUSY;
                        // The start cycle is itself one of the MDU_LAT-1 hold
                        // cycles, so the counter is loaded with MDU_LAT-2.
                        cnt_d       = CNT_W'(MDU_LAT - 2);
                    end else if (load_use) begin
                        // One bubble is enough: next cycle the load is in MEM
                        // and forwarding supplies the operand.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    // EX is frozen here, so branch and load-use cannot occur.
                    mdu_busy = 1'b1;
                    if (cnt_q != '0) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_hold     = 1'b1;
                        cnt_d       = cnt_q - 1'b1;
                    end else begin
                        mdu_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic load_stall_ev;

    // A load-use bubble is the only case where id_ex_flush is asserted
    // without if_id_flush.
    assign load_stall_ev = id_ex_flush && !if_id_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_stall_cnt <= '0;
            mdu_stall_cnt  <= '0;
            flush_cnt      <= '0;
        end else begin
            if (load_stall_ev && (load_stall_cnt != 32'hFFFF_FFFF))
                load_stall_cnt <= load_stall_cnt + 32'd1;
            if (ex_hold && (mdu_stall_cnt != 32'hFFFF_FFFF))
                mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
            if (if_id_flush && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed testbench for hazard_unit with the default MDU_LAT=4.
//
// Each stimulus step drives one cycle of inputs just after the rising edge.
// It then pushes the hand-computed output vector into a scoreboard queue.
// A separate monitor pops one entry on every falling edge and compares it
// against the DUT outputs.
//
// Expected vector bit order:
//   {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, mdu_busy, mdu_done}
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam logic [6:0] E_PASS  = 7'b1100000;
    localparam logic [6:0] E_LOAD  = 7'b0001000;
    localparam logic [6:0] E_FLUSH = 7'b1111000;
    localparam logic [6:0] E_MDU0  = 7'b0000100;
    localparam logic [6:0] E_BUSY  = 7'b0000110;
    localparam logic [6:0] E_DONE  = 7'b1100011;

    typedef struct {
        logic [8*16-1:0] name;
        logic [6:0]      exp;
        logic            chk_perf;
        logic [31:0]     lc;
        logic [31:0]     mc;
        logic [31:0]     fc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, ID_EX_reg = '0;
    logic       ID_EX_memRead = 1'b0, mdu_start = 1'b0, branch_taken = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic       ex_hold, mdu_busy, mdu_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_stall_cnt, mdu_stall_cnt, flush_cnt;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_unit #(.WIDTH(5), .MDU_LAT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .rs1           (rs1),
        .rs2           (rs2),
        .ID_EX_reg     (ID_EX_reg),
        .ID_EX_memRead (ID_EX_memRead),
        .mdu_start     (mdu_start),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_hold       (ex_hold),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .load_stall_cnt(load_stall_cnt),
        .mdu_stall_cnt (mdu_stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    task automatic step(input logic [8*16-1:0] name, input logic rst,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] dreg, input logic mr,
                        input logic mdu, input logic br,
                        input logic [6:0] exp, input logic chk,
                        input logic [31:0] lc, input logic [31:0] mc,
                        input logic [31:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        rs1           = r1;
        rs2           = r2;
        ID_EX_reg     = dreg;
        ID_EX_memRead = mr;
        mdu_start     = mdu;
        branch_taken  = br;
        e.name     = name;
        e.exp      = exp;
        e.chk_perf = chk;
        e.lc       = lc;
        e.mc       = mc;
        e.fc       = fc;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per presented cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = exp_q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                   ex_hold, mdu_busy, mdu_done};
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %0s: outputs got %b expected %b", e.name, act, e.exp);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e.chk_perf) begin
                tests++;
                if ({load_stall_cnt, mdu_stall_cnt, flush_cnt} !== {e.lc, e.mc, e.fc}) begin
                    fails++;
                    $display("FAIL %0s_perf: counters got %0d/%0d/%0d expected %0d/%0d/%0d",
                             e.name, load_stall_cnt, mdu_stall_cnt, flush_cnt,
                             e.lc, e.mc, e.fc);
                end
            end
`endif
        end
    end

    initial begin
        //     name             rst rs1 rs2 dreg mr mdu br exp      chk lc mc fc
        step("reset",          1,  0,  0,  0,  0, 0,  0, E_PASS,  1,  0, 0, 0);
        step("no_match",       0,  3,  4,  5,  1, 0,  0, E_PASS,  0,  0, 0, 0);
        step("load_use_rs2",   0,  3,  5,  5,  1, 0,  0, E_LOAD,  0,  0, 0, 0);
        step("after_bubble",   0,  3,  5,  5,  0, 0,  0, E_PASS,  0,  0, 0, 0);
        step("x0_no_hazard",   0,  0,  0,  0,  1, 0,  0, E_PASS,  1,  1, 0, 0);
        step("load_use_rs1",   0,  7,  2,  7,  1, 0,  0, E_LOAD,  0,  0, 0, 0);
        step("br_over_load",   0,  7,  2,  7,  1, 0,  1, E_FLUSH, 0,  0, 0, 0);
        step("br_with_mdu",    0,  1,  2,  3,  0, 1,  1, E_FLUSH, 0,  0, 0, 0);
        step("idle_after_br",  0,  1,  2,  3,  0, 0,  0, E_PASS,  1,  2, 0, 2);
        step("mdu_t0",         0,  1,  2,  3,  0, 1,  0, E_MDU0,  0,  0, 0, 0);
        step("mdu_t1",         0,  1,  2,  3,  0, 1,  0, E_BUSY,  0,  0, 0, 0);
        step("mdu_t2_ignore",  0,  3,  2,  3,  1, 1,  1, E_BUSY,  0,  0, 0, 0);
        step("mdu_t3_done",    0,  1,  2,  3,  0, 1,  0, E_DONE,  0,  0, 0, 0);
        step("t4_load_use",    0,  9,  2,  9,  1, 0,  0, E_LOAD,  1,  2, 3, 2);
        step("t5_pass",        0,  9,  2,  9,  0, 0,  0, E_PASS,  1,  3, 3, 2);
        step("mdu2_t0",        0,  1,  2,  3,  0, 1,  0, E_MDU0,  0,  0, 0, 0);
        step("reset_mid_mdu",  1,  1,  2,  3,  0, 1,  0, E_PASS,  0,  0, 0, 0);
        step("post_reset",     0,  1,  2,  3,  0, 0,  0, E_PASS,  1,  0, 0, 0);
        step("post_reset2",    0,  1,  2,  3,  0, 0,  0, E_PASS,  0,  0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
